// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, funct3 codes and access legality helpers for the load/store unit
package lsu_pkg;

  localparam int LSU_XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Only the five size/sign encodings are meaningful for this unit.
  function automatic logic f3_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // Halfwords need 2-byte alignment, words need 4-byte alignment.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    if ((f3 == F3_H) || (f3 == F3_HU)) mis = off[0];
    else if (f3 == F3_W)               mis = (off != 2'b00);
    return mis;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - memory-side request/response bus of the load/store unit
interface load_store_unit_if;
  import lsu_pkg::*;

  logic                mem_req;
  logic                mem_we;
  logic [LSU_XLEN-1:0] mem_addr;
  logic [3:0]          mem_be;
  logic [LSU_XLEN-1:0] mem_wdata;
  logic                mem_gnt;
  logic                mem_rvalid;
  logic [LSU_XLEN-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/load_store_unit_align.sv
// rtl/load_store_unit_align.sv - combinational lane alignment and sign/zero extension of load data
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] ext_data
);

  logic [31:0] shifted;

  // Bring the addressed byte/halfword down to bit 0, then extend by access type.
  always_comb begin
    shifted  = rdata >> {offset, 3'b000};
    ext_data = shifted;
    case (funct3)
      F3_B:    ext_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    ext_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   ext_data = {24'd0, shifted[7:0]};
      F3_HU:   ext_data = {16'd0, shifted[15:0]};
      default: ext_data = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit between execute stage and memory bus
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lsu_valid,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  lsu_busy,
  output logic                  lsu_done,
  output logic                  lsu_err,
  load_store_unit_if.master     mem
);

  lsu_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [2:0]            funct3_q, funct3_d;
  logic                  we_q, we_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] read_data_q, read_data_d;

  logic                  start;
  logic                  start_bad;
  logic [DATA_WIDTH-1:0] load_ext;

  load_align u_load_align (
    .rdata    (mem.mem_rdata),
    .offset   (addr_q[1:0]),
    .funct3   (funct3_q),
    .ext_data (load_ext)
  );

  // Next-state, latch capture and core-side handshake outputs.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    funct3_d    = funct3_q;
    we_d        = we_q;
    err_d       = err_q;
    read_data_d = read_data_q;

    start     = lsu_valid && (MemRead || MemWrite) &&
                ((state_q == ST_IDLE) || (state_q == ST_RESP));
    start_bad = !f3_legal(funct3) || is_misaligned(funct3, ALUResult[1:0]);

    case (state_q)
      ST_REQ:  if (mem.mem_gnt) state_d = we_q ? ST_RESP : ST_WAIT;
      ST_WAIT: if (mem.mem_rvalid) begin
                 read_data_d = load_ext;
                 state_d     = ST_RESP;
               end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A start in RESP overrides the return to IDLE so back-to-back accesses have no gap.
    if (start) begin
      addr_d   = ALUResult;
      wdata_d  = WriteData;
      funct3_d = funct3;
      we_d     = MemWrite;
      err_d    = start_bad;
      state_d  = start_bad ? ST_RESP : ST_REQ;
    end

    lsu_busy = start || (state_q == ST_REQ) || (state_q == ST_WAIT);
    lsu_done = (state_q == ST_RESP);
    lsu_err  = (state_q == ST_RESP) && err_q;
  end

  // Memory request lanes are derived purely from the latched access.
  always_comb begin
    mem.mem_req   = (state_q == ST_REQ);
    mem.mem_we    = we_q;
    mem.mem_addr  = {addr_q[DATA_WIDTH-1:2], 2'b00};
    mem.mem_be    = 4'b1111;
    mem.mem_wdata = wdata_q;
    case (funct3_q)
      F3_B, F3_BU: begin
        mem.mem_be    = 4'b0001 << addr_q[1:0];
        mem.mem_wdata = {4{wdata_q[7:0]}};
      end
      F3_H, F3_HU: begin
        mem.mem_be    = 4'b0011 << addr_q[1:0];
        mem.mem_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        mem.mem_be    = 4'b1111;
        mem.mem_wdata = wdata_q;
      end
    endcase
  end

  // State and latched fields; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      funct3_q    <= 3'b000;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      funct3_q    <= funct3_d;
      we_q        <= we_d;
      err_q       <= err_d;
      read_data_q <= read_data_d;
    end
  end

  assign ReadData = read_data_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data and address width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 lsu_valid  input  1  execute-stage result valid this cycle.
REQ-005 MemRead  input  1  instruction is a load.
REQ-006 MemWrite  input  1  instruction is a store.
REQ-007 funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 ALUResult  input  32  effective byte address from execute.
REQ-009 WriteData  input  32  store data (rs2 value).
REQ-010 ReadData  output  32  registered, aligned, extended load result.
REQ-011 lsu_busy  output  1  stall request to the core.
REQ-012 lsu_done  output  1  one-cycle completion pulse.
REQ-013 lsu_err  output  1  one-cycle pulse for a misaligned access or illegal funct3.
REQ-014 mem_req / mem_we  output  1 each  memory request and write qualifier.
REQ-015 mem_addr  output  32  word address, ALUResult with bits [1:0] forced to 0.
REQ-016 mem_be / mem_wdata  output  4 / 32  byte enables and lane-replicated store data.
REQ-017 mem_gnt / mem_rvalid  input  1 each  request accepted / read data valid.
REQ-018 mem_rdata  input  32  read word.

Function
REQ-019 The FSM SHALL have states IDLE, REQ, WAIT, RESP.
REQ-020 Start condition: lsu_valid=1 and (MemRead or MemWrite) while the state is IDLE or RESP.
  - lsu_valid with neither MemRead nor MemWrite is a no-op: no pulse, no busy.
REQ-021 MemWrite=1 with MemRead=1 SHALL be treated as a store.
REQ-022 On start, the unit SHALL latch the address, data, funct3 and write flag.
  - Legal access: next state REQ.
  - Misaligned access (H/HU with addr[0]=1, W with addr[1:0]!=0) or illegal funct3: next state RESP with lsu_err=1 in RESP; no memory request is issued and ReadData is unchanged.
REQ-023 In REQ, mem_req=1 with stable mem_addr/mem_we/mem_be/mem_wdata until mem_gnt=1.
  - Store with gnt: next state RESP.
  - Load with gnt: next state WAIT.
REQ-024 In WAIT, mem_rvalid=1 SHALL load ReadData and move to RESP; mem_rvalid outside WAIT is ignored.
REQ-025 lsu_done=1 exactly in RESP, then the FSM returns to IDLE, or goes to REQ/RESP if a new start is accepted in that cycle.
REQ-026 lsu_busy = start condition OR state in {REQ, WAIT}; it SHALL be 0 in RESP unless a new start occurs.
REQ-027 mem_be by offset o=addr[1:0]: B = 0001<<o; H = 0011<<o; W = 1111.
REQ-028 mem_wdata: B replicates byte[7:0] to all four lanes; H replicates [15:0] to both halves; W passes data through.
REQ-029 Load extract: shift rdata right by 8*o, then sign-extend (B, H) or zero-extend (BU, HU) from bit 7 or bit 15; W passes through.
REQ-030 Minimum latency: store 2 cycles from start to done (gnt on first REQ cycle); load 3 cycles (rvalid on first WAIT cycle).
REQ-031 mem_req SHALL be 0 in IDLE, WAIT and RESP; mem_we, mem_be and mem_wdata are don't-care when mem_req=0.

Reset
REQ-032 While rst=1: state=IDLE, ReadData=0, all latched fields=0, mem_req=0, lsu_done=0, lsu_err=0, lsu_busy=0.
REQ-033 Reset mid-transaction SHALL abort immediately (mem_req falls asynchronously); any later mem_rvalid for the aborted request is discarded.

Structure
REQ-034 Package lsu_pkg SHALL hold the state enum and the funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
REQ-035 Load alignment and extension SHALL be a combinational sub-module named load_align (inputs rdata, offset, funct3; output extended data).

Verification
REQ-036 SW addr=0x100 data=0xDEADBEEF, gnt on first REQ cycle -> mem_addr=0x100, be=1111, wdata=0xDEADBEEF, done 2 cycles after start.
REQ-037 LB addr=0x103, rdata=0x80FF1122 -> be=1000, ReadData=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-038 LH addr=0x102, rdata=0x8001ABCD -> ReadData=0xFFFF8001; LW addr=0x101 -> lsu_err pulse, no mem_req, ReadData unchanged.
REQ-039 SB addr=0x201 data=0x000000A5, gnt held low 3 cycles -> mem_req high 4 cycles with stable outputs, wdata=0xA5A5A5A5, be=0010, busy high throughout.
REQ-040 Back-to-back: LW done in the same cycle a new SW starts -> no idle cycle between them, and mem_req asserts in the following cycle.
REQ-041 rst asserted in WAIT, rvalid arriving 1 cycle later -> state IDLE, ReadData=0, no done pulse.
